// File: rtl/soc_system_cpu_s0_mul_seq_if.sv
// Request/response handshake bundle between a requester and the multiply sequencer.
interface soc_system_cpu_s0_mul_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        rsp_valid;
  logic [31:0] rsp_result;
  logic        rsp_ready;

  modport master (
    output req_valid, req_op, req_src1, req_src2, rsp_ready,
    input  req_ready, rsp_valid, rsp_result
  );

  modport slave (
    input  req_valid, req_op, req_src1, req_src2, rsp_ready,
    output req_ready, rsp_valid, rsp_result
  );
endinterface

// File: rtl/soc_system_cpu_s0_mul_seq.sv
// Multi-pass 32x32 multiply sequencer driving a 32x16 multiplier cell with
// configurable result latency; produces MUL (low word) and MULX* (high word).
module soc_system_cpu_s0_mul_seq #(
  parameter int unsigned CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  soc_system_cpu_s0_mul_seq_if.slave bus,
  output logic [31:0] A_mul_src1,
  output logic [31:0] A_mul_src2,
  input  logic [31:0] A_mul_cell_result
);

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULXUU = 2'd1;
  localparam logic [1:0] OP_MULXSU = 2'd2;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, FINAL, DONE} state_e;

  state_e                         state_q;
  logic [1:0]                     op_q;
  logic [31:0]                    a_q;
  logic [31:0]                    b_q;
  logic [63:0]                    acc_q;
  logic [1:0]                     pass_q;
  logic [CELL_LATENCY-1:0]        tag_v_q;
  logic [CELL_LATENCY-1:0][1:0]   tag_idx_q;
  logic                           req_ready_q;
  logic                           rsp_valid_q;
  logic [31:0]                    rsp_result_q;
  logic [31:0]                    src1_q;
  logic [31:0]                    src2_q;

  logic                           tag_out_v;
  logic [1:0]                     tag_out_idx;
  logic [1:0]                     last_pass;
  logic [63:0]                    acc_next_c;
  logic [31:0]                    final_c;

  // Cell operands for pass p: MUL splits the cross terms, MULX forms four 16x16 partials.
  function automatic logic [63:0] pass_ops(logic [1:0] op, logic [1:0] p,
                                           logic [31:0] a, logic [31:0] b);
    logic [31:0] s1;
    logic [31:0] s2;
    if (op == OP_MUL) begin
      if (p == 2'd0) begin
        s1 = a;
        s2 = {16'h0, b[15:0]};
      end else begin
        s1 = {b[31:16], 16'h0};
        s2 = {16'h0, a[15:0]};
      end
    end else begin
      s1 = {16'h0, p[0] ? a[31:16] : a[15:0]};
      s2 = {16'h0, p[1] ? b[31:16] : b[15:0]};
    end
    return {s1, s2};
  endfunction

  assign tag_out_v   = tag_v_q[CELL_LATENCY-1];
  assign tag_out_idx = tag_idx_q[CELL_LATENCY-1];
  assign last_pass   = (op_q == OP_MUL) ? 2'd1 : 2'd3;

  assign A_mul_src1     = src1_q;
  assign A_mul_src2     = src2_q;
  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;

  // Accumulator update for the partial product whose tag is emerging this cycle.
  always_comb begin
    acc_next_c = acc_q;
    if (op_q == OP_MUL) begin
      acc_next_c[31:0] = acc_q[31:0] + A_mul_cell_result;
    end else begin
      case (tag_out_idx)
        2'd0:       acc_next_c = acc_q + {32'h0, A_mul_cell_result};
        2'd1, 2'd2: acc_next_c = acc_q + {16'h0, A_mul_cell_result, 16'h0};
        default:    acc_next_c = acc_q + {A_mul_cell_result, 32'h0};
      endcase
    end
  end

  // Final word: signed variants correct the unsigned high product.
  always_comb begin
    final_c = acc_q[63:32];
    case (op_q)
      OP_MUL:    final_c = acc_q[31:0];
      OP_MULXUU: final_c = acc_q[63:32];
      OP_MULXSU: final_c = acc_q[63:32] - (a_q[31] ? b_q : 32'h0);
      default:   final_c = acc_q[63:32] - (a_q[31] ? b_q : 32'h0)
                                        - (b_q[31] ? a_q : 32'h0);
    endcase
  end

  // Sequencer FSM, tag pipe, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= 2'd0;
      a_q          <= 32'h0;
      b_q          <= 32'h0;
      acc_q        <= 64'h0;
      pass_q       <= 2'd0;
      tag_v_q      <= '0;
      tag_idx_q    <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 32'h0;
      src1_q       <= 32'h0;
      src2_q       <= 32'h0;
    end else begin
      tag_v_q[0]   <= (state_q == ISSUE);
      tag_idx_q[0] <= pass_q;
      for (int i = 1; i < int'(CELL_LATENCY); i++) begin
        tag_v_q[i]   <= tag_v_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end

      if (tag_out_v) acc_q <= acc_next_c;

      case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            op_q               <= bus.req_op;
            a_q                <= bus.req_src1;
            b_q                <= bus.req_src2;
            acc_q              <= 64'h0;
            pass_q             <= 2'd0;
            {src1_q, src2_q}   <= pass_ops(bus.req_op, 2'd0, bus.req_src1, bus.req_src2);
            req_ready_q        <= 1'b0;
            state_q            <= ISSUE;
          end
        end
        ISSUE: begin
          if (pass_q == last_pass) begin
            src1_q  <= 32'h0;
            src2_q  <= 32'h0;
            state_q <= DRAIN;
          end else begin
            pass_q           <= pass_q + 2'd1;
            {src1_q, src2_q} <= pass_ops(op_q, pass_q + 2'd1, a_q, b_q);
          end
        end
        DRAIN: begin
          if (tag_out_v && (tag_out_idx == last_pass)) state_q <= FINAL;
        end
        FINAL: begin
          rsp_result_q <= final_c;
          rsp_valid_q  <= 1'b1;
          state_q      <= DONE;
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_system_cpu_s0_mul_seq.sv
// Directed bench: four sequencers (cell latency 1..4) share one stimulus stream.
module tb_soc_system_cpu_s0_mul_seq;
  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        rsp_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;

  logic [NI-1:0] req_ready_v;
  logic [NI-1:0] rsp_valid_v;
  logic [31:0]   rsp_result_v [NI];
  logic [31:0]   src1_v [NI];
  logic [31:0]   src2_v [NI];

  int n_cmp  = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  int base = 0;
  int first_cyc [NI];
  logic [31:0] got_res [NI];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference multiplier-cell arithmetic.
  function automatic logic [31:0] cell_f(logic [31:0] s1, logic [31:0] s2);
    logic [31:0] lo;
    logic [31:0] hi;
    lo = 32'(s1[15:0]) * 32'(s2[15:0]);
    hi = 32'(s1[31:16]) * 32'(s2[15:0]);
    return lo + (hi << 16);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LAT = g + 1;
    soc_system_cpu_s0_mul_seq_if bus ();
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] cres;
    logic [31:0] cpipe [LAT];

    assign bus.req_valid = req_valid;
    assign bus.req_op    = req_op;
    assign bus.req_src1  = req_src1;
    assign bus.req_src2  = req_src2;
    assign bus.rsp_ready = rsp_ready;
    assign req_ready_v[g]  = bus.req_ready;
    assign rsp_valid_v[g]  = bus.rsp_valid;
    assign rsp_result_v[g] = bus.rsp_result;
    assign src1_v[g] = s1;
    assign src2_v[g] = s2;

    always @(posedge clk) begin
      cpipe[0] <= cell_f(s1, s2);
      for (int k = 1; k < LAT; k++) cpipe[k] <= cpipe[k-1];
    end
    assign cres = cpipe[LAT-1];

    soc_system_cpu_s0_mul_seq #(.CELL_LATENCY(LAT)) u_dut (
      .clk               (clk),
      .reset             (reset),
      .bus               (bus),
      .A_mul_src1        (s1),
      .A_mul_src2        (s2),
      .A_mul_cell_result (cres)
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  // Cell operand rules that hold in every cycle.
  task automatic cell_checks();
    for (int g = 0; g < NI; g++) begin
      check($sformatf("src2_hi_zero[L%0d]", g + 1), {16'h0, src2_v[g][31:16]}, 32'h0);
      if (req_ready_v[g])
        check($sformatf("idle_src_zero[L%0d]", g + 1), src1_v[g] | src2_v[g], 32'h0);
    end
  endtask

  task automatic wait_all_idle();
    int n;
    rsp_ready = 1'b1;
    n = 0;
    while (!(&req_ready_v) && n < 40) begin
      sample();
      n++;
    end
    if (!(&req_ready_v)) check("idle_timeout", 32'(req_ready_v), 32'hF);
  endtask

  task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    req_valid = 1'b1;
    sample();
    req_valid = 1'b0;
    base = edge_cnt;
    check("accepted_ready_low", 32'(req_ready_v), 32'h0);
  endtask

  // Issue one op on all instances and check result and first-valid cycle.
  task automatic expect_op(input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
    int n;
    wait_all_idle();
    for (int g = 0; g < NI; g++) first_cyc[g] = -1;
    accept(op, a, b);
    n = 0;
    while (n < 40 && (first_cyc[NI-1] < 0)) begin
      sample();
      cell_checks();
      for (int g = 0; g < NI; g++)
        if (rsp_valid_v[g] && first_cyc[g] < 0) begin
          first_cyc[g] = edge_cnt - base;
          got_res[g]   = rsp_result_v[g];
        end
      n++;
    end
    for (int g = 0; g < NI; g++) begin
      check($sformatf("result op%0d[L%0d]", op, g + 1), got_res[g], exp);
      check($sformatf("latency op%0d[L%0d]", op, g + 1), 32'(first_cyc[g]),
            32'(((op == 2'd0) ? 3 : 5) + g + 1));
    end
  endtask

  initial begin
    int n;
    logic [31:0] held;
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_op = 2'd0; req_src1 = 32'h0; req_src2 = 32'h0;
    for (int g = 0; g < NI; g++) got_res[g] = 32'h0;
    repeat (3) sample();
    for (int g = 0; g < NI; g++) begin
      check($sformatf("rst_req_ready[L%0d]", g + 1), 32'(req_ready_v[g]), 32'h1);
      check($sformatf("rst_rsp_valid[L%0d]", g + 1), 32'(rsp_valid_v[g]), 32'h0);
      check($sformatf("rst_rsp_result[L%0d]", g + 1), rsp_result_v[g], 32'h0);
      check($sformatf("rst_src[L%0d]", g + 1), src1_v[g] | src2_v[g], 32'h0);
    end
    reset = 1'b0;
    sample();

    expect_op(2'd0, 32'h00010003, 32'h00020005, 32'h000B000F);
    expect_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    expect_op(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    expect_op(2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    expect_op(2'd3, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000);
    expect_op(2'd1, 32'h00010000, 32'h00010000, 32'h00000001);
    expect_op(2'd2, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF);
    expect_op(2'd2, 32'h00000002, 32'hFFFFFFFF, 32'h00000001);
    expect_op(2'd3, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000);
    expect_op(2'd3, 32'hFFFF0000, 32'h00030000, 32'hFFFFFFFD);
    expect_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    expect_op(2'd0, 32'h12345678, 32'h00000010, 32'h23456780);

    // Back-pressure in DONE: response holds, new requests are not taken.
    wait_all_idle();
    rsp_ready = 1'b0;
    accept(2'd0, 32'h00000007, 32'h00000006);
    n = 0;
    while (!rsp_valid_v[0] && n < 20) begin
      sample();
      n++;
    end
    check("hold_valid_seen", 32'(rsp_valid_v[0]), 32'h1);
    held = rsp_result_v[0];
    check("hold_first_result", held, 32'h0000002A);
    req_op = 2'd1; req_src1 = 32'h11111111; req_src2 = 32'h22222222;
    req_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      sample();
      check("hold_rsp_valid", 32'(rsp_valid_v[0]), 32'h1);
      check("hold_rsp_result", rsp_result_v[0], held);
      check("hold_req_ready", 32'(req_ready_v[0]), 32'h0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    sample();
    check("hs_rsp_valid_drop", 32'(rsp_valid_v), 32'h0);
    check("hs_req_ready_all", 32'(req_ready_v), 32'hF);
    repeat (3) sample();
    check("hs_no_ghost_accept", 32'(req_ready_v), 32'hF);

    // Reset mid-operation aborts without a response.
    wait_all_idle();
    accept(2'd0, 32'h00001234, 32'h00005678);
    sample();
    sample();
    reset = 1'b1;
    sample();
    reset = 1'b0;
    check("abort_req_ready", 32'(req_ready_v), 32'hF);
    check("abort_rsp_valid", 32'(rsp_valid_v), 32'h0);
    for (int g = 0; g < NI; g++)
      check($sformatf("abort_src[L%0d]", g + 1), src1_v[g] | src2_v[g], 32'h0);
    for (int c = 0; c < 8; c++) begin
      sample();
      check("abort_no_rsp", 32'(rsp_valid_v), 32'h0);
    end
    expect_op(2'd0, 32'h00000003, 32'h00000005, 32'h0000000F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
